// File: rtl/rx_frame_filter.sv
// Hunts for a sync byte, buffers one address/length/payload frame and forwards it downstream only
// when its XOR checksum matches. Bad, oversize and stalled frames are dropped and counted.
module rx_frame_filter #(
  parameter logic [7:0]  SYNC        = 8'hAA,
  parameter int unsigned MAX_LEN     = 64,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       err_pulse,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam int unsigned IdxW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TmoW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      MaxLen  = 8'(MAX_LEN);

  typedef enum logic [2:0] {StHunt, StAddr, StLen, StPayload, StCsum, StFwd} state_e;

  state_e          state;
  logic [7:0]      addr, len, csum, idx;
  logic [TmoW-1:0] tmo;
  logic [8:0]      out_pos;  // 0 = addr, 1 = len, 2.. = payload
  logic [7:0]      buffer [MAX_LEN];

  logic            accept, out_fire, in_frame;
  logic            len_bad, tmo_hit, frame_err;
  logic [IdxW-1:0] wr_idx, rd_idx;
  logic [7:0]      next_byte;

  assign in_ready  = (state != StFwd);
  assign busy      = (state != StHunt);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign in_frame  = state inside {StAddr, StLen, StPayload, StCsum};
  assign len_bad   = (in_data == 8'd0) || (in_data > MaxLen);
  // An accepted byte always beats the timeout in the same cycle.
  assign tmo_hit   = in_frame && !accept && (tmo == TmoLast);
  assign frame_err = tmo_hit
                  || (accept && (state == StLen) && len_bad)
                  || (accept && (state == StCsum) && (in_data != csum));

  assign wr_idx    = IdxW'(idx);
  assign rd_idx    = IdxW'(out_pos - 9'd1);
  assign next_byte = (out_pos == 9'd0) ? len : buffer[rd_idx];

  always_ff @(posedge clk) begin
    if (accept && (state == StPayload)) begin
      buffer[wr_idx] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= StHunt;
      addr      <= '0;
      len       <= '0;
      csum      <= '0;
      idx       <= '0;
      tmo       <= '0;
      out_pos   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= frame_err;
      if (frame_err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end

      if (!in_frame || accept || tmo_hit) begin
        tmo <= '0;
      end else begin
        tmo <= tmo + TmoW'(1);
      end

      unique case (state)
        StHunt: begin
          if (accept && (in_data == SYNC)) state <= StAddr;
        end
        StAddr: begin
          if (accept) begin
            addr  <= in_data;
            csum  <= in_data;
            state <= StLen;
          end
        end
        StLen: begin
          if (accept) begin
            if (len_bad) begin
              state <= StHunt;
            end else begin
              len   <= in_data;
              csum  <= csum ^ in_data;
              idx   <= '0;
              state <= StPayload;
            end
          end
        end
        StPayload: begin
          if (accept) begin
            csum <= csum ^ in_data;
            idx  <= idx + 8'd1;
            if (idx == len - 8'd1) state <= StCsum;
          end
        end
        StCsum: begin
          if (accept) begin
            if (in_data == csum) begin
              state     <= StFwd;
              out_valid <= 1'b1;
              out_data  <= addr;
              out_last  <= 1'b0;
              out_pos   <= '0;
            end else begin
              state <= StHunt;
            end
          end
        end
        StFwd: begin
          if (out_fire) begin
            if (out_last) begin
              state     <= StHunt;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_data <= next_byte;
              out_last <= (out_pos == {1'b0, len});
              out_pos  <= out_pos + 9'd1;
            end
          end
        end
        default: state <= StHunt;
      endcase

      if (tmo_hit) state <= StHunt;
    end
  end

endmodule

// File: tb/tb_rx_frame_filter.sv
// Bench for rx_frame_filter: frame vectors from a table, scoreboarded output stream, and
// hand-written timeout, back-pressure, reset and saturation sequences.
module tb_rx_frame_filter;

  localparam logic [7:0]  SYNC    = 8'hAA;
  localparam int unsigned MAX_LEN = 64;
  localparam int unsigned TMO     = 20;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       err_pulse;
  logic [7:0] err_cnt;
  logic       busy;

  rx_frame_filter #(
    .SYNC        (SYNC),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  len;
    int          npay;
    logic [63:0] pay;
    logic [7:0]  corrupt;
    bit          fwd;
  } vec_t;

  vec_t       vecs [7];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         pulse_cnt = 0;
  int         exp_pulses = 0;
  int         exp_err_cnt = 0;
  int         mode = 0;  // 0: out_ready high, 1: 1,0,0 pattern, 2: out_ready low
  logic [8:0] exp_q [$];
  logic [7:0] pay_buf [64];
  logic [8:0] exp_item;
  logic [7:0] prev_data;
  logic       prev_last = 1'b0;
  logic       prev_stall = 1'b0;
  logic       prev_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("in_ready_wait", 32'(in_ready), 32'd1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] l, input int npay,
                            input logic [7:0] corrupt, input bit fwd);
    logic [7:0] cs;
    if (fwd) begin
      exp_q.push_back({1'b0, a});
      exp_q.push_back({1'b0, l});
      for (int i = 0; i < npay; i++) exp_q.push_back({(i == npay - 1), pay_buf[i]});
    end else begin
      exp_pulses++;
      if (exp_err_cnt < 255) exp_err_cnt++;
    end
    send_byte(SYNC);
    send_byte(a);
    send_byte(l);
    cs = a ^ l;
    for (int i = 0; i < npay; i++) begin
      send_byte(pay_buf[i]);
      cs = cs ^ pay_buf[i];
    end
    send_byte(cs ^ corrupt);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (!busy && (exp_q.size() == 0)) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_pending", 32'(exp_q.size()) + 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err_cnt));
    check({tag, "_pulses"}, 32'(pulse_cnt), 32'(exp_pulses));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Downstream ready pattern, changed just after each rising edge.
  initial begin
    int ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        1: begin
          out_ready = (ph == 0);
          ph = (ph + 1) % 3;
        end
        2: out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: scoreboard pops, stall stability, FWD back-pressure, pulse width.
  initial begin
    forever begin
      @(negedge clk);
      if (prev_stall && n_rst) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid) check("fwd_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          exp_item = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(exp_item[7:0]));
          check("out_last", 32'(out_last), 32'(exp_item[8]));
        end
      end
      if (err_pulse) begin
        pulse_cnt++;
        check("err_pulse_width", 32'(prev_pulse), 32'd0);
      end
      prev_pulse = err_pulse;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    n_rst    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    vecs[0] = '{addr: 8'h09, len: 8'h02, npay: 2, pay: 64'h2211, corrupt: 8'h00, fwd: 1'b1};
    vecs[1] = '{addr: 8'h09, len: 8'h02, npay: 2, pay: 64'h2211, corrupt: 8'h01, fwd: 1'b0};
    vecs[2] = '{addr: 8'h5A, len: 8'h03, npay: 3, pay: 64'h030201, corrupt: 8'h00, fwd: 1'b1};
    vecs[3] = '{addr: 8'h00, len: 8'h00, npay: 2, pay: 64'h4433, corrupt: 8'h00, fwd: 1'b0};
    vecs[4] = '{addr: 8'h7E, len: 8'h41, npay: 2, pay: 64'h4433, corrupt: 8'h00, fwd: 1'b0};
    vecs[5] = '{addr: 8'hAA, len: 8'h01, npay: 1, pay: 64'hAA, corrupt: 8'h00, fwd: 1'b1};
    vecs[6] = '{addr: 8'hFF, len: 8'h04, npay: 4, pay: 64'h08040201, corrupt: 8'h00, fwd: 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    n_rst = 1'b1;

    // Table: each forwarded frame must stream without bubbles, addr first.
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < vecs[i].npay; j++) pay_buf[j] = vecs[i].pay[8*j +: 8];
      send_frame(vecs[i].addr, vecs[i].len, vecs[i].npay, vecs[i].corrupt, vecs[i].fwd);
      if (vecs[i].fwd) begin
        for (int k = 0; k < int'(vecs[i].len) + 2; k++) begin
          @(negedge clk);
          check("stream_valid", 32'(out_valid), 32'd1);
          if (k == 0) check("first_byte_addr", 32'(out_data), 32'(vecs[i].addr));
        end
      end
      wait_idle();
      check_errs("vec");
    end

    // Stall after AA 05 03 11: error exactly TMO idle cycles later.
    send_byte(SYNC);
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h11);
    repeat (TMO) @(negedge clk);
    check("tmo_before_pulse", 32'(err_pulse), 32'd0);
    check("tmo_before_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("tmo_pulse", 32'(err_pulse), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    exp_pulses++;
    exp_err_cnt++;
    pay_buf[0] = 8'h11;
    pay_buf[1] = 8'h22;
    send_frame(8'h09, 8'h02, 2, 8'h00, 1'b1);
    wait_idle();
    check_errs("tmo");

    // Byte accepted on the cycle the timeout would fire wins.
    exp_q.push_back({1'b0, 8'h05});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b1, 8'h11});
    send_byte(SYNC);
    send_byte(8'h05);
    send_byte(8'h01);
    repeat (TMO - 1) @(negedge clk);
    send_byte(8'h11);
    send_byte(8'h05 ^ 8'h01 ^ 8'h11);
    wait_idle();
    check_errs("tmo_edge");

    // MAX_LEN payload under a 1,0,0 ready pattern.
    mode = 1;
    for (int j = 0; j < 64; j++) pay_buf[j] = 8'(j * 7 + 1);
    send_frame(8'h3C, 8'(MAX_LEN), MAX_LEN, 8'h00, 1'b1);
    wait_idle();
    mode = 0;
    check_errs("maxlen");

    // Reset mid-PAYLOAD: everything discarded, error count cleared.
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h11);
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    reset_checks("rst_pay");
    exp_err_cnt = 0;
    n_rst = 1'b1;
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h01 ^ 8'h03 ^ 8'h11 ^ 8'h22 ^ 8'h33);
    repeat (20) @(negedge clk);
    check("rst_pay_idle_busy", 32'(busy), 32'd0);
    check_errs("rst_pay");

    // Reset mid-FWD while downstream stalls.
    mode = 2;
    pay_buf[0] = 8'h11;
    pay_buf[1] = 8'h22;
    send_frame(8'h09, 8'h02, 2, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    check("fwd_hold_valid", 32'(out_valid), 32'd1);
    check("fwd_hold_data", 32'(out_data), 32'h09);
    n_rst = 1'b0;
    @(negedge clk);
    reset_checks("rst_fwd");
    exp_q.delete();
    n_rst = 1'b1;
    mode = 0;
    repeat (20) @(negedge clk);
    check("rst_fwd_idle_valid", 32'(out_valid), 32'd0);

    // 300 LEN=0 frames: counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      send_byte(SYNC);
      send_byte(8'h01);
      send_byte(8'h00);
      exp_pulses++;
      if (exp_err_cnt < 255) exp_err_cnt++;
      if (i == 254 || i == 255) check("sat_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
    end
    repeat (2) @(negedge clk);
    check_errs("sat");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
